// File: rtl/mux_2to1.sv
// mux_2to1: 2:1 select (sel ? in1 : in0) behind a valid/ready pipeline of DELAY stages; DELAY=0 is purely combinational.
// Latency DELAY cycles, one transfer per cycle; stalled stages collapse bubbles and in_ready = stage 0 empty or advancing.
// Optional out_par (XOR of the selected data, carried alongside it) exists only when MUX_2TO1_PARITY_EN is defined.
module mux_2to1 #(
    parameter int DELAY = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX_2TO1_PARITY_EN
    ,
    output logic             out_par
`endif
);

    logic [WIDTH-1:0] sel_dat;
    assign sel_dat = sel ? in1 : in0;

    generate
        if (DELAY == 0) begin : g_comb
            assign out       = sel_dat;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
`ifdef MUX_2TO1_PARITY_EN
            assign out_par   = ^sel_dat;
`endif
        end else begin : g_pipe
            logic [DELAY-1:0] vld_q;
            logic [DELAY-1:0] vld_d;
            logic [DELAY-1:0] move;
            logic [DELAY-1:0] load;
            logic [WIDTH-1:0] dat_q [DELAY];
            logic             free;
            logic             in_xfer;

            // Walk from the output back: a stage moves when the slot ahead is free or itself moving.
            always_comb begin
                free = out_ready;
                move = '0;
                for (int i = DELAY - 1; i >= 0; i--) begin
                    move[i] = vld_q[i] & free;
                    free    = ~vld_q[i] | move[i];
                end
            end

            assign in_ready = free;
            assign in_xfer  = in_valid & free;

            always_comb begin
                load    = '0;
                vld_d   = '0;
                load[0] = in_xfer;
                for (int i = 1; i < DELAY; i++) begin
                    load[i] = move[i-1];
                end
                for (int i = 0; i < DELAY; i++) begin
                    vld_d[i] = load[i] | (vld_q[i] & ~move[i]);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < DELAY; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    if (load[0]) dat_q[0] <= sel_dat;
                    for (int i = 1; i < DELAY; i++) begin
                        if (load[i]) dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign out       = dat_q[DELAY-1];
            assign out_valid = vld_q[DELAY-1];

`ifdef MUX_2TO1_PARITY_EN
            logic [DELAY-1:0] par_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    par_q <= '0;
                end else begin
                    if (load[0]) par_q[0] <= ^sel_dat;
                    for (int i = 1; i < DELAY; i++) begin
                        if (load[i]) par_q[i] <= par_q[i-1];
                    end
                end
            end

            assign out_par = par_q[DELAY-1];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: five instances (DELAY 0,1,2,3,7) share one stimulus; a queue-of-entries model checks every cycle.
module tb_mux_2to1;

    localparam int N = 5;
    localparam int DL [N] = '{0, 1, 2, 3, 7};
    localparam int WD [N] = '{4, 4, 8, 8, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0 = 8'h00;
    logic [7:0] in1 = 8'h00;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [N-1:0] rdy;
    logic [N-1:0] ovl;
    logic [N-1:0] pv;
    logic [3:0]   o0, o1;
    logic [7:0]   o2, o3;
    logic [0:0]   o4;
    logic [7:0]   outv [N];

    int nvec = 0;
    int nerr = 0;

    int         mcnt  [N];
    int         mpos  [N][8];
    logic [7:0] mdat  [N][8];
    logic [7:0] mlast [N];

    always #5 clk = ~clk;

    mux_2to1 #(.DELAY(0), .WIDTH(4)) u_d0 (
        .clk(clk), .rst(rst), .in0(in0[3:0]), .in1(in1[3:0]), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy[0]), .out(o0), .out_valid(ovl[0]), .out_ready(out_ready)
`ifdef MUX_2TO1_PARITY_EN
        , .out_par(pv[0])
`endif
    );
    mux_2to1 #(.DELAY(1), .WIDTH(4)) u_d1 (
        .clk(clk), .rst(rst), .in0(in0[3:0]), .in1(in1[3:0]), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy[1]), .out(o1), .out_valid(ovl[1]), .out_ready(out_ready)
`ifdef MUX_2TO1_PARITY_EN
        , .out_par(pv[1])
`endif
    );
    mux_2to1 #(.DELAY(2), .WIDTH(8)) u_d2 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy[2]), .out(o2), .out_valid(ovl[2]), .out_ready(out_ready)
`ifdef MUX_2TO1_PARITY_EN
        , .out_par(pv[2])
`endif
    );
    mux_2to1 #(.DELAY(3), .WIDTH(8)) u_d3 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy[3]), .out(o3), .out_valid(ovl[3]), .out_ready(out_ready)
`ifdef MUX_2TO1_PARITY_EN
        , .out_par(pv[3])
`endif
    );
    mux_2to1 #(.DELAY(7), .WIDTH(1)) u_d7 (
        .clk(clk), .rst(rst), .in0(in0[0:0]), .in1(in1[0:0]), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy[4]), .out(o4), .out_valid(ovl[4]), .out_ready(out_ready)
`ifdef MUX_2TO1_PARITY_EN
        , .out_par(pv[4])
`endif
    );

`ifndef MUX_2TO1_PARITY_EN
    assign pv = '0;
`endif

    assign outv[0] = {4'b0, o0};
    assign outv[1] = {4'b0, o1};
    assign outv[2] = o2;
    assign outv[3] = o3;
    assign outv[4] = {7'b0, o4};

    function automatic logic [7:0] wmask(input int w);
        return 8'((16'd1 << w) - 16'd1);
    endfunction

    task automatic chk(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s inst%0d (DELAY=%0d) at %0t: got %h, expected %h", name, n, DL[n], $time, act, exp);
        end
    endtask

    // Model: each in-flight entry has a slot position; per edge the oldest leaves on an output
    // transfer, then every entry steps forward one slot unless the slot ahead stays occupied.
    task automatic model_cycle(input int n);
        int         d;
        logic [7:0] m, sd, e_out;
        logic       e_vld, e_rdy;
        d  = DL[n];
        m  = wmask(WD[n]);
        sd = (sel ? in1 : in0) & m;
        if (d == 0) begin
            e_out = sd;
            e_vld = in_valid;
            e_rdy = out_ready;
        end else begin
            e_out = mlast[n];
            e_vld = (mcnt[n] > 0) && (mpos[n][0] == d - 1);
            if (e_vld && out_ready) begin
                for (int k = 1; k < mcnt[n]; k++) begin
                    mpos[n][k-1] = mpos[n][k];
                    mdat[n][k-1] = mdat[n][k];
                end
                mcnt[n]--;
            end
            for (int k = 0; k < mcnt[n]; k++) begin
                int lim;
                lim = (k == 0) ? d - 1 : mpos[n][k-1] - 1;
                if (mpos[n][k] < lim) begin
                    mpos[n][k]++;
                    if (mpos[n][k] == d - 1) mlast[n] = mdat[n][k];
                end
            end
            e_rdy = 1'b1;
            if (mcnt[n] > 0) e_rdy = (mpos[n][mcnt[n]-1] > 0);
        end
        chk("out", n, outv[n], e_out);
        chk("out_valid", n, {7'b0, ovl[n]}, {7'b0, e_vld});
        chk("in_ready", n, {7'b0, rdy[n]}, {7'b0, e_rdy});
`ifdef MUX_2TO1_PARITY_EN
        chk("out_par", n, {7'b0, pv[n]}, {7'b0, ^e_out});
`endif
        if (d > 0) begin
            if (rst) begin
                mcnt[n]  = 0;
                mlast[n] = 8'h00;
            end else if (in_valid && e_rdy) begin
                mpos[n][mcnt[n]] = 0;
                mdat[n][mcnt[n]] = sd;
                mcnt[n]++;
                if (d == 1) mlast[n] = sd;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < N; n++) model_cycle(n);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        int got;
        for (int n = 0; n < N; n++) begin
            mcnt[n]  = 0;
            mlast[n] = 8'h00;
            for (int k = 0; k < 8; k++) begin
                mpos[n][k] = 0;
                mdat[n][k] = 8'h00;
            end
        end

        // Reset state and first transfers through DELAY=1 / DELAY=0.
        do_reset;
        @(negedge clk);
        chk("rst_out_valid", 3, {7'b0, ovl[3]}, 8'h00);
        chk("rst_out", 3, outv[3], 8'h00);
        chk("rst_in_ready", 3, {7'b0, rdy[3]}, 8'h01);
        tick;
        out_ready = 1'b1; in0 = 8'h03; in1 = 8'h0C; sel = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("d0_same_cycle", 0, outv[0], 8'h03);
        tick;
        sel = 1'b1;
        @(negedge clk);
        chk("d1_first", 1, outv[1], 8'h03);
        chk("d1_first_vld", 1, {7'b0, ovl[1]}, 8'h01);
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("d1_second", 1, outv[1], 8'h0C);
        tick;
        @(negedge clk);
        chk("d1_idle_vld", 1, {7'b0, ovl[1]}, 8'h00);
        chk("d1_hold", 1, outv[1], 8'h0C);

        // Single bit through seven stages: valid exactly seven edges after acceptance.
        do_reset;
        in0 = 8'h01; in1 = 8'h00; sel = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("d7_latency", 4, {7'b0, ovl[4]}, (k == 7) ? 8'h01 : 8'h00);
            if (k == 7) chk("d7_data", 4, outv[4], 8'h00);
            tick;
        end

        // Fill DELAY=3 under backpressure, then drain with a simultaneous in/out transfer.
        do_reset;
        out_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            in0 = 8'(v); in1 = ~8'(v);
            @(negedge clk);
            chk("d3_accept", 3, {7'b0, rdy[3]}, 8'h01);
            tick;
        end
        in0 = 8'h04; in1 = 8'hFB;
        @(negedge clk);
        chk("d3_full", 3, {7'b0, rdy[3]}, 8'h00);
        tick;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) chk("d3_full_xfer", 3, {7'b0, rdy[3]}, 8'h01);
            if (ovl[3]) begin
                if (got < 4) chk("d3_order", 3, outv[3], 8'(got + 1));
                got++;
            end
            tick;
            in_valid = 1'b0;
        end
        chk("d3_count", 3, 8'(got), 8'h04);

        // Reset with two entries in flight in DELAY=2; the input in the reset cycle is dropped.
        do_reset;
        out_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; in0 = 8'h11;
        tick;
        in0 = 8'h22;
        tick;
        @(negedge clk);
        chk("d2_loaded", 2, outv[2], 8'h11);
        chk("d2_stalled", 2, {7'b0, rdy[2]}, 8'h00);
        tick;
        rst = 1'b1; in0 = 8'h33;
        tick;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("d2_rst_vld", 2, {7'b0, ovl[2]}, 8'h00);
        chk("d2_rst_out", 2, outv[2], 8'h00);
        chk("d2_rst_rdy", 2, {7'b0, rdy[2]}, 8'h01);
        tick;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("d2_nothing", 2, {7'b0, ovl[2]}, 8'h00);
            tick;
        end

        // Combinational DELAY=0 follows sel and mirrors out_ready.
        in0 = 8'h0A; in1 = 8'h05; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sel = c[0];
            out_ready = (c % 3 != 0);
            @(negedge clk);
            chk("d0_sel", 0, outv[0], c[0] ? 8'h05 : 8'h0A);
            chk("d0_ready", 0, {7'b0, rdy[0]}, (c % 3 != 0) ? 8'h01 : 8'h00);
            tick;
        end

`ifdef MUX_2TO1_PARITY_EN
        do_reset;
        out_ready = 1'b1; sel = 1'b0; in_valid = 1'b1; in0 = 8'h07;
        tick;
        in0 = 8'h06;
        @(negedge clk);
        chk("par_odd", 1, {7'b0, pv[1]}, 8'h01);
        chk("par_odd_dat", 1, outv[1], 8'h07);
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("par_even", 1, {7'b0, pv[1]}, 8'h00);
        chk("par_even_dat", 1, outv[1], 8'h06);
        tick;
`endif

        // Mixed valid/ready sweep with a mid-run reset; checked by the model only.
        for (int c = 0; c < 80; c++) begin
            in0 = 8'(c * 37 + 1);
            in1 = 8'(c * 11 + 5);
            sel = c[1] ^ c[3];
            in_valid = (c % 5 != 3);
            out_ready = (c % 7 < 4) || (c > 60);
            rst = (c == 45);
            tick;
        end
        rst = 1'b0; in_valid = 1'b0;
        tick;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
